// File: rtl/spi_slave_response_sequencer.sv
// spi_slave_response_sequencer
//   Transmit-side sequencer of the SD-style SPI slave command engine. Takes a
//   parsed command (index, argument, CRC verdict), decides the R1/R7 response
//   and, for a single-block read, streams data token, block payload fetched
//   from a byte memory port, and CRC16. Owns the block-length register.
//
//   Optional feature macro: SPI_RESP_CRC16_EN
//     defined   : CRC16-CCITT (0x1021, init 0, MSB first) over the payload
//     undefined : CRC bytes are sent as 0xFF, 0xFF and no CRC logic exists
//
//   Ports:
//     clock, reset        system clock, synchronous active-high reset
//     io_CommandValid     one-cycle pulse, command frame received
//     io_CommandCrcOk     CRC7 verdict (qualified by io_CommandValid)
//     io_Command          command index (qualified by io_CommandValid)
//     io_CommandArgument  command argument (qualified by io_CommandValid)
//     io_TxByte/Valid     byte offered to the shifter, held until io_TxReady
//     io_TxReady          shifter accepts byte when io_TxValid && io_TxReady
//     io_MemReq/Addr      one-cycle byte read request
//     io_MemData/Valid    read data, any latency >= 1
//     io_DataBlockSize    current block length
//     io_Busy             sequencer not idle
//     io_InIdle           card idle flag (R1 bit 0)
module spi_slave_response_sequencer #(
  parameter int unsigned NCR_BYTES     = 1,
  parameter int unsigned DEFAULT_BLOCK = 512,
  parameter int unsigned MAX_BLOCK     = 512
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_CommandValid,
  input  logic        io_CommandCrcOk,
  input  logic [5:0]  io_Command,
  input  logic [31:0] io_CommandArgument,
  output logic [7:0]  io_TxByte,
  output logic        io_TxValid,
  input  logic        io_TxReady,
  output logic        io_MemReq,
  output logic [31:0] io_MemAddr,
  input  logic [7:0]  io_MemData,
  input  logic        io_MemValid,
  output logic [31:0] io_DataBlockSize,
  output logic        io_Busy,
  output logic        io_InIdle
);

  typedef enum logic [3:0] {
    S_IDLE, S_FILL, S_R1, S_R7, S_TOKEN, S_FETCH, S_DATA, S_CRC_HI, S_CRC_LO
  } state_t;

  state_t      state;
  logic        app_flag;
  logic [7:0]  r1_reg;
  logic        resp_r7;
  logic        resp_read;
  logic [31:0] arg_reg;
  logic [2:0]  cnt;
  logic [31:0] base_addr;
  logic [31:0] n;
  logic        req_sent;
  logic [7:0]  data_byte;

`ifdef SPI_RESP_CRC16_EN
  logic [15:0] crc;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic [7:0]  s;
    r = c;
    s = d;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[15] ^ s[7]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
      s = {s[6:0], 1'b0};
    end
    return r;
  endfunction
`endif

  // Command decode, evaluated against the flags as they stand before this
  // command updates them.
  logic [7:0] base;
  logic [7:0] dec_r1;
  logic       dec_r7;
  logic       dec_read;
  logic       dec_idle;
  logic       dec_app;
  logic       dec_blk_load;
  logic       arg_ok;

  always_comb begin
    base         = {7'b0, io_InIdle};
    dec_r1       = base | 8'h04;
    dec_r7       = 1'b0;
    dec_read     = 1'b0;
    dec_idle     = io_InIdle;
    dec_app      = 1'b0;
    dec_blk_load = 1'b0;
    arg_ok       = (io_CommandArgument != '0) && (io_CommandArgument <= 32'(MAX_BLOCK));
    if (!io_CommandCrcOk) begin
      dec_r1  = base | 8'h08;
      dec_app = app_flag;
    end else begin
      case (io_Command)
        6'd0: begin
          dec_r1   = 8'h01;
          dec_idle = 1'b1;
        end
        6'd8: begin
          dec_r1 = base;
          dec_r7 = 1'b1;
        end
        6'd55: begin
          dec_r1  = base;
          dec_app = 1'b1;
        end
        6'd41: begin
          if (app_flag) begin
            dec_r1   = 8'h00;
            dec_idle = 1'b0;
          end
        end
        6'd16: begin
          if (arg_ok) begin
            dec_r1       = base;
            dec_blk_load = 1'b1;
          end else begin
            dec_r1 = base | 8'h40;
          end
        end
        6'd17: begin
          if (!io_InIdle) begin
            dec_r1   = 8'h00;
            dec_read = 1'b1;
          end else begin
            dec_r1 = 8'h05;
          end
        end
        default: ;
      endcase
    end
  end

  // Byte offered in each transmitting state.
  logic [7:0] tx_next;

  always_comb begin
    tx_next = 8'hFF;
    case (state)
      S_R1:    tx_next = r1_reg;
      S_R7: begin
        case (cnt[1:0])
          2'd2:    tx_next = 8'h01;
          2'd3:    tx_next = arg_reg[7:0];
          default: tx_next = 8'h00;
        endcase
      end
      S_TOKEN: tx_next = 8'hFE;
      S_DATA:  tx_next = data_byte;
`ifdef SPI_RESP_CRC16_EN
      S_CRC_HI: tx_next = crc[15:8];
      S_CRC_LO: tx_next = crc[7:0];
`endif
      default: tx_next = 8'hFF;
    endcase
  end

  assign io_Busy = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= S_IDLE;
      io_TxValid       <= 1'b0;
      io_TxByte        <= 8'hFF;
      io_MemReq        <= 1'b0;
      io_MemAddr       <= '0;
      io_DataBlockSize <= 32'(DEFAULT_BLOCK);
      io_InIdle        <= 1'b1;
      app_flag         <= 1'b0;
      r1_reg           <= 8'hFF;
      resp_r7          <= 1'b0;
      resp_read        <= 1'b0;
      arg_reg          <= '0;
      cnt              <= '0;
      base_addr        <= '0;
      n                <= '0;
      req_sent         <= 1'b0;
      data_byte        <= 8'hFF;
`ifdef SPI_RESP_CRC16_EN
      crc              <= '0;
`endif
    end else begin
      io_MemReq <= 1'b0;
      case (state)
        S_IDLE: begin
          io_TxValid <= 1'b0;
          if (io_CommandValid) begin
            r1_reg    <= dec_r1;
            resp_r7   <= dec_r7;
            resp_read <= dec_read;
            arg_reg   <= io_CommandArgument;
            io_InIdle <= dec_idle;
            app_flag  <= dec_app;
            if (dec_blk_load) io_DataBlockSize <= io_CommandArgument;
            cnt       <= '0;
            state     <= S_FILL;
          end
        end
        S_FETCH: begin
          if (!req_sent) begin
            io_MemReq  <= 1'b1;
            io_MemAddr <= base_addr + n;
            req_sent   <= 1'b1;
          end else if (io_MemValid) begin
            data_byte <= io_MemData;
`ifdef SPI_RESP_CRC16_EN
            crc <= crc16_byte(crc, io_MemData);
`endif
            state <= S_DATA;
          end
        end
        default: begin
          // Load on one cycle, release on acceptance: a dead cycle between
          // bytes keeps each byte's value tied to the state that owns it.
          if (!io_TxValid) begin
            io_TxByte  <= tx_next;
            io_TxValid <= 1'b1;
          end else if (io_TxReady) begin
            io_TxValid <= 1'b0;
            case (state)
              S_FILL: begin
                if (cnt == 3'(NCR_BYTES - 1)) begin
                  cnt   <= '0;
                  state <= S_R1;
                end else begin
                  cnt <= cnt + 3'd1;
                end
              end
              S_R1: begin
                cnt <= '0;
                if (resp_r7)        state <= S_R7;
                else if (resp_read) state <= S_TOKEN;
                else                state <= S_IDLE;
              end
              S_R7: begin
                if (cnt == 3'd3) state <= S_IDLE;
                else             cnt   <= cnt + 3'd1;
              end
              S_TOKEN: begin
                base_addr <= arg_reg;
                n         <= '0;
                req_sent  <= 1'b0;
`ifdef SPI_RESP_CRC16_EN
                crc       <= '0;
`endif
                state     <= S_FETCH;
              end
              S_DATA: begin
                n <= n + 32'd1;
                if (n + 32'd1 == io_DataBlockSize) begin
                  state <= S_CRC_HI;
                end else begin
                  req_sent <= 1'b0;
                  state    <= S_FETCH;
                end
              end
              S_CRC_HI: state <= S_CRC_LO;
              default:  state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_response_sequencer.sv
// Testbench for spi_slave_response_sequencer: directed and randomized command
// sequences, transmit sink with optional stalls, variable-latency byte memory,
// and a reference model of the expected response stream built from the
// command rules.
module tb_spi_slave_response_sequencer;

  localparam int unsigned NCR  = 1;
  localparam int unsigned DEFB = 512;
  localparam int unsigned MAXB = 512;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_crc_ok;
  logic [5:0]  cmd;
  logic [31:0] cmd_arg;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_valid;
  logic [31:0] blk_size;
  logic        busy;
  logic        in_idle;

  spi_slave_response_sequencer #(
    .NCR_BYTES(NCR),
    .DEFAULT_BLOCK(DEFB),
    .MAX_BLOCK(MAXB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io_CommandValid(cmd_valid),
    .io_CommandCrcOk(cmd_crc_ok),
    .io_Command(cmd),
    .io_CommandArgument(cmd_arg),
    .io_TxByte(tx_byte),
    .io_TxValid(tx_valid),
    .io_TxReady(tx_ready),
    .io_MemReq(mem_req),
    .io_MemAddr(mem_addr),
    .io_MemData(mem_data),
    .io_MemValid(mem_valid),
    .io_DataBlockSize(blk_size),
    .io_Busy(busy),
    .io_InIdle(in_idle)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Environment controls
  int         rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready
  int         mem_lat  = 3;
  logic [7:0] mem_key  = 8'h00;

  // Observed traffic
  logic [7:0]  rx_q[$];
  logic [31:0] addr_q[$];
  int          double_req = 0;

  // Reference model state and expectations
  logic        m_idle;
  logic        m_app;
  logic [31:0] m_blk;
  logic [7:0]  exp_q[$];
  logic [31:0] exp_a[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem_fn(input logic [31:0] a);
    return a[7:0] ^ mem_key;
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int b = 7; b >= 0; b--) begin
      fb = r[15] ^ d[b];
      r  = r << 1;
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  // Sink, stall-hold checker and memory model, all acting at the falling edge.
  int          pend_cnt = 0;
  logic [31:0] pend_addr;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_byte;
  logic        prev_req = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      pend_cnt   = 0;
      prev_stall = 1'b0;
      prev_req   = 1'b0;
      mem_valid  = 1'b0;
      tx_ready   = 1'b1;
    end else begin
      case (rdy_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ($urandom_range(0, 2) != 0);
        default: tx_ready = 1'b0;
      endcase
      if (prev_stall) begin
        chk("tx_hold_valid", 32'(tx_valid), 32'd1);
        chk("tx_hold_byte", 32'(tx_byte), 32'(prev_byte));
      end
      prev_stall = tx_valid && !tx_ready;
      prev_byte  = tx_byte;
      if (tx_valid && tx_ready) rx_q.push_back(tx_byte);

      mem_valid = 1'b0;
      mem_data  = 8'($urandom);
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_valid = 1'b1;
          mem_data  = mem_fn(pend_addr);
        end
      end
      if (mem_req) begin
        addr_q.push_back(mem_addr);
        if (prev_req) double_req++;
        pend_cnt  = mem_lat;
        pend_addr = mem_addr;
      end
      prev_req = mem_req;
    end
  end

  task automatic model_reset();
    m_idle = 1'b1;
    m_app  = 1'b0;
    m_blk  = 32'(DEFB);
  endtask

  // Expected response bytes and memory addresses for one accepted command.
  task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic ok);
    logic [7:0]  base;
    logic [7:0]  r1;
    logic [7:0]  d;
    logic [15:0] crc;
    logic [31:0] a;
    bit          r7 = 0;
    bit          rd = 0;
    exp_q.delete();
    exp_a.delete();
    base = m_idle ? 8'h01 : 8'h00;
    if (!ok) begin
      r1 = base | 8'h08;
    end else begin
      r1 = base | 8'h04;
      case (idx)
        6'd0:  begin r1 = 8'h01; m_idle = 1'b1; end
        6'd8:  begin r1 = base; r7 = 1; end
        6'd55: r1 = base;
        6'd41: if (m_app) begin r1 = 8'h00; m_idle = 1'b0; end
        6'd16: begin
          if (arg >= 1 && arg <= 32'(MAXB)) begin m_blk = arg; r1 = base; end
          else r1 = base | 8'h40;
        end
        6'd17: if (!m_idle) begin r1 = 8'h00; rd = 1; end else r1 = 8'h05;
        default: ;
      endcase
      m_app = (idx == 6'd55);
    end
    for (int i = 0; i < int'(NCR); i++) exp_q.push_back(8'hFF);
    exp_q.push_back(r1);
    if (r7) begin
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h01);
      exp_q.push_back(arg[7:0]);
    end
    if (rd) begin
      exp_q.push_back(8'hFE);
      crc = 16'h0000;
      for (int i = 0; i < int'(m_blk); i++) begin
        a = arg + 32'(i);
        exp_a.push_back(a);
        d = mem_fn(a);
        exp_q.push_back(d);
        crc = crc_step(crc, d);
      end
`ifdef SPI_RESP_CRC16_EN
      exp_q.push_back(crc[15:8]);
      exp_q.push_back(crc[7:0]);
`else
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFF);
`endif
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic pulse_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic ok);
    @(negedge clock);
    cmd        = idx;
    cmd_arg    = arg;
    cmd_crc_ok = ok;
    cmd_valid  = 1'b1;
    @(negedge clock);
    cmd_valid  = 1'b0;
    cmd        = 6'($urandom);
    cmd_arg    = $urandom;
    cmd_crc_ok = 1'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 30000) begin
      @(negedge clock);
      t++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic compare(input string tag);
    int nb;
    chk({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
    nb = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < nb; i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    chk({tag, "_nreq"}, 32'(addr_q.size()), 32'(exp_a.size()));
    nb = (addr_q.size() < exp_a.size()) ? addr_q.size() : exp_a.size();
    for (int i = 0; i < nb; i++)
      chk($sformatf("%s_addr%0d", tag, i), addr_q[i], exp_a[i]);
    chk({tag, "_memreq_pulse"}, 32'(double_req), 32'd0);
    chk({tag, "_in_idle"}, 32'(in_idle), 32'(m_idle));
    chk({tag, "_blk"}, blk_size, m_blk);
  endtask

  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic ok);
    model_cmd(idx, arg, ok);
    rx_q.delete();
    addr_q.delete();
    pulse_cmd(idx, arg, ok);
    wait_idle();
    compare(tag);
  endtask

  initial begin
    logic [7:0]  b0;
    logic [5:0]  ri;
    logic [31:0] ra;
    int          t;
    cmd = '0; cmd_arg = '0; cmd_crc_ok = 1'b1; tx_ready = 1'b1;
    mem_valid = 1'b0; mem_data = '0;
    do_reset();

    // Reset state
    @(negedge clock);
    chk("rst_txvalid", 32'(tx_valid), 32'd0);
    chk("rst_txbyte", 32'(tx_byte), 32'hFF);
    chk("rst_memreq", 32'(mem_req), 32'd0);
    chk("rst_memaddr", mem_addr, 32'd0);
    chk("rst_blk", blk_size, 32'd512);
    chk("rst_inidle", 32'(in_idle), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);

    // Main flow, always ready, 3-cycle memory, data = addr[7:0]
    rdy_mode = 0; mem_lat = 3; mem_key = 8'h00;
    run_cmd("cmd0", 6'd0, 32'h0, 1'b1);
    run_cmd("cmd8", 6'd8, 32'h0000_01AA, 1'b1);
    run_cmd("init_cmd0", 6'd0, 32'h0, 1'b1);
    run_cmd("cmd55", 6'd55, 32'h0, 1'b1);
    run_cmd("cmd41", 6'd41, 32'h0, 1'b1);
    run_cmd("cmd16_16", 6'd16, 32'd16, 1'b1);
    run_cmd("cmd17_2048", 6'd17, 32'd2048, 1'b1);

    // Block-length boundaries and address wrap
    run_cmd("cmd16_512", 6'd16, 32'd512, 1'b1);
    run_cmd("cmd16_513", 6'd16, 32'd513, 1'b1);
    run_cmd("cmd16_3", 6'd16, 32'd3, 1'b1);
    mem_lat = 1;
    run_cmd("cmd17_wrap", 6'd17, 32'hFFFF_FFFE, 1'b1);
    run_cmd("cmd16_1", 6'd16, 32'd1, 1'b1);
    run_cmd("cmd17_one", 6'd17, 32'h0000_0040, 1'b1);

    // Error responses
    run_cmd("e_cmd0", 6'd0, 32'h0, 1'b1);
    run_cmd("e_cmd17_idle", 6'd17, 32'd100, 1'b1);
    run_cmd("e_badcrc", 6'd0, 32'h0, 1'b0);
    run_cmd("e_cmd16_0", 6'd16, 32'd0, 1'b1);
    run_cmd("e_cmd16_1024", 6'd16, 32'd1024, 1'b1);
    run_cmd("e_cmd5", 6'd5, 32'h0, 1'b1);
    run_cmd("e_cmd41_noapp", 6'd41, 32'h0, 1'b1);
    run_cmd("e_cmd55", 6'd55, 32'h0, 1'b1);
    run_cmd("e_cmd8_clr", 6'd8, 32'h0000_0055, 1'b1);
    run_cmd("e_cmd41_cleared", 6'd41, 32'h0, 1'b1);

    // Stall: byte held while not ready; command pulsed mid-transfer ignored
    rdy_mode = 2;
    model_cmd(6'd8, 32'h0000_00A5, 1'b1);
    rx_q.delete();
    addr_q.delete();
    pulse_cmd(6'd8, 32'h0000_00A5, 1'b1);
    repeat (3) @(negedge clock);
    b0 = tx_byte;
    chk("stall_valid", 32'(tx_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        cmd = 6'd16; cmd_arg = 32'd8; cmd_crc_ok = 1'b1; cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clock);
      chk($sformatf("stall_byte%0d", i), 32'(tx_byte), 32'(b0));
    end
    cmd_valid = 1'b0;
    rdy_mode = 0;
    wait_idle();
    compare("stall_cmd8");

    // Randomized command stream, random ready and memory latency
    rdy_mode = 1;
    for (int k = 0; k < 40; k++) begin
      mem_lat = $urandom_range(1, 4);
      mem_key = 8'($urandom);
      case ($urandom_range(0, 9))
        0:       ri = 6'd0;
        1:       ri = 6'd8;
        2, 3:    ri = 6'd55;
        4:       ri = 6'd41;
        5:       ri = 6'd16;
        6, 7:    ri = 6'd17;
        8:       ri = 6'd5;
        default: ri = 6'($urandom);
      endcase
      ra = $urandom;
      if (ri == 6'd16) begin
        case ($urandom_range(0, 5))
          0:       ra = 32'd0;
          1:       ra = 32'd1024;
          2:       ra = 32'd513;
          default: ra = $urandom_range(1, 24);
        endcase
      end
      if (ri == 6'd17 && $urandom_range(0, 3) == 0) ra = 32'hFFFF_FFF8;
      run_cmd($sformatf("rnd%0d", k), ri, ra, 1'($urandom_range(0, 9) != 0));
    end

    // Reset in the middle of a block read
    rdy_mode = 0; mem_lat = 2; mem_key = 8'h00;
    run_cmd("pre_cmd55", 6'd55, 32'h0, 1'b1);
    run_cmd("pre_cmd41", 6'd41, 32'h0, 1'b1);
    run_cmd("pre_cmd16", 6'd16, 32'd32, 1'b1);
    model_cmd(6'd17, 32'h0000_1000, 1'b1);
    rx_q.delete();
    addr_q.delete();
    pulse_cmd(6'd17, 32'h0000_1000, 1'b1);
    t = 0;
    while (rx_q.size() < 6 && t < 2000) begin
      @(negedge clock);
      t++;
    end
    chk("midread_progress", 32'(rx_q.size() >= 6), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_txvalid", 32'(tx_valid), 32'd0);
    chk("midrst_memreq", 32'(mem_req), 32'd0);
    chk("midrst_blk", blk_size, 32'd512);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_inidle", 32'(in_idle), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    run_cmd("post_rst_cmd8", 6'd8, 32'h0000_01AA, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
